// File: rtl/ssr_pkg.sv
// Shared types for the universal shift register: operation modes, word-framing FSM states
// and the bit-count width helper.
package ssr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } ssr_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ssr_state_e;

  // Bit_Cnt must hold 0..WIDTH, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Bus bundle between a controller and the universal shift register.
// The rotate signal exists only when SSR_ROTATE_EN is defined.
interface universal_shift_register_if #(
  parameter int WIDTH = 8
);
  import ssr_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  ssr_mode_e          mode;
  logic               ser_in_msb;
  logic               ser_in_lsb;
  logic [WIDTH-1:0]   par_in;
`ifdef SSR_ROTATE_EN
  logic               rotate;
`endif
  logic [WIDTH-1:0]   par_out;
  logic               ser_out_lsb;
  logic               ser_out_msb;
  logic [CNT_W-1:0]   bit_cnt;
  logic               word_done;
  logic               busy;

  modport master (
    output mode, ser_in_msb, ser_in_lsb, par_in,
`ifdef SSR_ROTATE_EN
    output rotate,
`endif
    input  par_out, ser_out_lsb, ser_out_msb, bit_cnt, word_done, busy
  );

  modport slave (
    input  mode, ser_in_msb, ser_in_lsb, par_in,
`ifdef SSR_ROTATE_EN
    input  rotate,
`endif
    output par_out, ser_out_lsb, ser_out_msb, bit_cnt, word_done, busy
  );

endinterface

// File: rtl/ssr_word_counter.sv
// Word framing for the shift register: counts shifts, wraps at WIDTH with a one-cycle
// word_done pulse, and tracks whether a word is partially shifted (busy).
module ssr_word_counter
  import ssr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  ssr_mode_e        mode,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ssr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // A shift that would reach WIDTH closes the word instead; direction changes keep counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (mode)
      MODE_SHR, MODE_SHL: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      MODE_LOAD: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign bit_cnt   = cnt_q;
  assign word_done = done_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register (hold / shift right / shift left / parallel load) with word framing.
// Optional macro SSR_ROTATE_EN adds a rotate input that recirculates the shifted-out bit.
module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                        clk,
  input logic                        rst,
  universal_shift_register_if.slave  bus
);
  import ssr_pkg::*;

  if (WIDTH < 2) begin : g_width_check
    $error("universal_shift_register: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] q, q_d;
  logic             shr_in, shl_in;

  // Bits entering at each end; while rotating they come from the opposite end of Q.
  always_comb begin
`ifdef SSR_ROTATE_EN
    shr_in = bus.rotate ? q[0]       : bus.ser_in_msb;
    shl_in = bus.rotate ? q[WIDTH-1] : bus.ser_in_lsb;
`else
    shr_in = bus.ser_in_msb;
    shl_in = bus.ser_in_lsb;
`endif
  end

  always_comb begin
    q_d = q;
    unique case (bus.mode)
      MODE_SHR:  q_d = {shr_in, q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q[WIDTH-2:0], shl_in};
      MODE_LOAD: q_d = bus.par_in;
      default:   q_d = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_d;
    end
  end

  assign bus.par_out     = q;
  assign bus.ser_out_lsb = q[0];
  assign bus.ser_out_msb = q[WIDTH-1];

  ssr_word_counter #(
    .WIDTH(WIDTH)
  ) u_word_counter (
    .clk       (clk),
    .rst       (rst),
    .mode      (bus.mode),
    .bit_cnt   (bus.bit_cnt),
    .word_done (bus.word_done),
    .busy      (bus.busy)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register at WIDTH=4: expected observations are queued
// as each cycle is driven and compared after the edge.
module tb_universal_shift_register;
  import ssr_pkg::*;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [3:0] q;
    logic [2:0] cnt;
    logic       done;
    logic       busy;
  } obs_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  obs_t exp_q[$];
  obs_t e, got;

  logic [3:0] m_q;
  int         m_cnt;
  logic       m_busy;

  universal_shift_register_if #(.WIDTH(WIDTH)) bus ();

  universal_shift_register #(
    .WIDTH(WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t sample();
    return '{bus.par_out, bus.bit_cnt, bus.word_done, bus.busy};
  endfunction

  task automatic push_exp(input logic [3:0] q, input int cnt, input logic done, input logic busy);
    exp_q.push_back('{q, 3'(cnt), done, busy});
  endtask

  task automatic apply_stimulus(input ssr_mode_e m, input logic msb, input logic lsb,
                                input logic [3:0] par);
    bus.mode       = m;
    bus.ser_in_msb = msb;
    bus.ser_in_lsb = lsb;
    bus.par_in     = par;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one clock edge (reset low); pushes the resulting observation.
  task automatic model_step(input ssr_mode_e m, input logic msb, input logic lsb,
                            input logic [3:0] par);
    logic done;
    done = 1'b0;
    case (m)
      MODE_SHR, MODE_SHL: begin
        m_q   = (m == MODE_SHR) ? {msb, m_q[3:1]} : {m_q[2:0], lsb};
        m_cnt = m_cnt + 1;
        if (m_cnt == WIDTH) begin
          m_cnt  = 0;
          done   = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end
      MODE_LOAD: begin
        m_q    = par;
        m_cnt  = 0;
        m_busy = 1'b0;
      end
      default: ;
    endcase
    push_exp(m_q, m_cnt, done, m_busy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp(4'h0, 0, 1'b0, 1'b0);
      apply_stimulus(MODE_LOAD, 1'b1, 1'b1, 4'hF);
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL reset[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [3:0] q_tab [4] = '{4'h5, 4'h2, 4'h1, 4'h0};
    logic       lsb_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    push_exp(4'hA, 0, 1'b0, 1'b0);
    apply_stimulus(MODE_LOAD, 1'b0, 1'b0, 4'hA);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL shr[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
      if (i == 4) break;
      tests_run++;
      if (bus.ser_out_lsb !== lsb_tab[i]) begin
        tests_failed++;
        $display("[TB] FAIL shr_ser_out_lsb[%0d]: got %b expected %b", i,
                 bus.ser_out_lsb, lsb_tab[i]);
      end
      push_exp(q_tab[i], (i + 1) % 4, i == 3, i != 3);
      apply_stimulus(MODE_SHR, 1'b0, 1'b0, 4'h0);
    end
  endtask

  task automatic test_shift_left();
    logic       in_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] q_tab  [4] = '{4'h1, 4'h2, 4'h5, 4'hB};
    for (int i = 0; i < 4; i++) begin
      push_exp(q_tab[i], (i + 1) % 4, i == 3, i != 3);
      apply_stimulus(MODE_SHL, 1'b0, in_tab[i], 4'h0);
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL shl[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
    end
  endtask

  // Starts from Q=4'hB, Bit_Cnt=0 left by the shift-left word.
  task automatic test_hold();
    ssr_mode_e  m_tab [7] = '{MODE_SHR, MODE_SHR, MODE_HOLD, MODE_HOLD, MODE_HOLD, MODE_SHR, MODE_SHR};
    logic       msb_tab [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] q_tab [7] = '{4'hD, 4'h6, 4'h6, 4'h6, 4'h6, 4'hB, 4'hD};
    int         c_tab [7] = '{1, 2, 2, 2, 2, 3, 0};
    for (int i = 0; i < 7; i++) begin
      push_exp(q_tab[i], c_tab[i], i == 6, i != 6);
      apply_stimulus(m_tab[i], msb_tab[i], 1'b0, 4'h0);
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL hold[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
    end
  endtask

  // Starts from Q=4'hD, Bit_Cnt=0.
  task automatic test_abort();
    ssr_mode_e  m_tab [14] = '{MODE_SHR, MODE_SHR, MODE_SHR, MODE_LOAD, MODE_SHR, MODE_SHR,
                               MODE_SHR, MODE_SHR, MODE_SHL, MODE_SHL, MODE_SHL, MODE_SHL,
                               MODE_SHL, MODE_SHL};
    logic       r_tab [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [3:0] q_tab [14] = '{4'h6, 4'h3, 4'h1, 4'h6, 4'h3, 4'h1, 4'h0, 4'h0, 4'h1, 4'h3,
                               4'h0, 4'h0, 4'h0, 4'h0};
    int         c_tab [14] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 0, 1, 2, 3};
    logic       d_tab [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic       b_tab [14] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 14; i++) begin
      rst = r_tab[i];
      push_exp(q_tab[i], c_tab[i], d_tab[i], b_tab[i]);
      apply_stimulus(m_tab[i], 1'b0, (i == 8 || i == 9), 4'h6);
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL abort[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int        pulses;
    ssr_mode_e m;
    logic      msb, lsb;
    pulses = 0;
    model_step(MODE_LOAD, 1'b0, 1'b0, 4'h3);
    apply_stimulus(MODE_LOAD, 1'b0, 1'b0, 4'h3);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3 * WIDTH; i++) begin
      m   = ($urandom_range(0, 1) == 0) ? MODE_SHR : MODE_SHL;
      msb = 1'($urandom_range(0, 1));
      lsb = 1'($urandom_range(0, 1));
      model_step(m, msb, lsb, 4'h0);
      apply_stimulus(m, msb, lsb, 4'h0);
      if (bus.word_done === 1'b1) pulses++;
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL b2b[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
    end
    tests_run++;
    if (pulses !== 3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_random();
    ssr_mode_e  m;
    logic       msb, lsb;
    logic [3:0] par;
    model_step(MODE_LOAD, 1'b0, 1'b0, 4'h0);
    apply_stimulus(MODE_LOAD, 1'b0, 1'b0, 4'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 60; i++) begin
      m   = ssr_mode_e'($urandom_range(0, 3));
      msb = 1'($urandom_range(0, 1));
      lsb = 1'($urandom_range(0, 1));
      par = 4'($urandom_range(0, 15));
      model_step(m, msb, lsb, par);
      apply_stimulus(m, msb, lsb, par);
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
    end
  endtask

`ifdef SSR_ROTATE_EN
  task automatic test_rotate();
    logic [3:0] q_tab [4] = '{4'hC, 4'h6, 4'h3, 4'h9};
    push_exp(4'h9, 0, 1'b0, 1'b0);
    apply_stimulus(MODE_LOAD, 1'b0, 1'b0, 4'h9);
    bus.rotate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front(); got = sample(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL rotate[%0d]: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i,
                 got.q, got.cnt, got.done, got.busy, e.q, e.cnt, e.done, e.busy);
      end
      if (i == 4) break;
      push_exp(q_tab[i], (i + 1) % 4, i == 3, i != 3);
      apply_stimulus(MODE_SHR, 1'b0, 1'b0, 4'h0);
    end
    bus.rotate = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_q          = 4'h0;
    m_cnt        = 0;
    m_busy       = 1'b0;
    rst          = 1'b1;
    bus.mode       = MODE_LOAD;
    bus.ser_in_msb = 1'b0;
    bus.ser_in_lsb = 1'b0;
    bus.par_in     = 4'hF;
`ifdef SSR_ROTATE_EN
    bus.rotate     = 1'b0;
`endif
    test_reset();
    test_shift_right();
    test_shift_left();
    test_hold();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef SSR_ROTATE_EN
    test_rotate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
